ram_bus_ctrl: RTL
=================

RAM_BUS_CTRL -- requirements
Module: ram_bus_ctrl

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte base address of the RAM window.
REQ-002 The block SHALL have parameter ADDR_BITS, default 13: byte-address width of the window (8 KiB).
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2: RAM clock edges from a read strobe to valid ram_rdata.
REQ-004 The block SHALL use one clock, clk_cpu; reset is asynchronous and active-low, port resetn.
REQ-005 clk_cpu  in  1  CPU/RAM clock; all state on the rising edge.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 mem_valid  in  1  CPU request valid (picorv32 native bus).
REQ-008 mem_addr  in  32  CPU byte address.
REQ-009 mem_wdata  in  32  CPU write data.
REQ-010 mem_wstrb  in  4  byte write strobes; 4'b0000 means read.
REQ-011 mem_ready  out  1  one-cycle completion pulse to the CPU.
REQ-012 mem_rdata  out  32  registered read data, valid while mem_ready=1.
REQ-013 ram_sel  out  1  RAM chip enable.
REQ-014 ram_wen  out  4  RAM per-byte write enables.
REQ-015 ram_address  out  ADDR_BITS  RAM byte address.
REQ-016 ram_wdata  out  32  RAM write data.
REQ-017 ram_rdata  in  32  RAM read data.

Function
REQ-018 A hit SHALL be defined as mem_valid=1 and mem_addr[31:ADDR_BITS]==BASE_ADDR[31:ADDR_BITS].
REQ-019 The FSM SHALL have states IDLE, ACCESS, WAIT, DONE.
REQ-020 In IDLE, a hit SHALL register the address, strobes and data and move to ACCESS on the next edge; a miss SHALL stay in IDLE with no outputs driven active.
REQ-021 In ACCESS, ram_sel SHALL be 1, ram_wen SHALL equal the registered strobes, and ram_address/ram_wdata SHALL equal the registered values, for exactly one cycle.
REQ-022 Writes (strobes!=0) SHALL go ACCESS->DONE; mem_ready SHALL pulse 2 cycles after the IDLE hit cycle.
REQ-023 Reads with READ_LATENCY=1 SHALL go ACCESS->DONE; reads with READ_LATENCY=2 SHALL go ACCESS->WAIT->DONE.
REQ-024 On entry to DONE for a read, mem_rdata SHALL capture ram_rdata; for writes mem_rdata SHALL hold its previous value.
REQ-025 In DONE, mem_ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-026 The FSM SHALL NOT accept a new request in DONE; back-to-back requests SHALL be separated by at least one IDLE cycle.
REQ-027 ram_sel and ram_wen SHALL be 0 in every state except ACCESS.
REQ-028 Once a request is accepted, deassertion of mem_valid SHALL NOT abort it; it SHALL complete, including the mem_ready pulse.
REQ-029 mem_addr[1:0] SHALL be passed to ram_address unchanged; byte selection is carried only by ram_wen.
REQ-030 The block SHALL never assert mem_ready for a miss.

Reset
REQ-031 Asserting resetn low SHALL immediately force state IDLE, mem_ready=0, mem_rdata=0, ram_sel=0, ram_wen=0, ram_address=0 and ram_wdata=0, including mid-transaction.
REQ-032 An interrupted write SHALL NOT be completed after reset release, and no mem_ready SHALL be issued for it.

Structure
REQ-033 The FSM state encoding and the legal READ_LATENCY range SHALL live in a shared package ram_bus_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the RAM array is instantiated alongside it at SoC level, not inside it.

Verification
REQ-035 Write 32'hDEADBEEF to 0x0000_0010 with strobe 4'b1111 -> one ACCESS cycle with ram_wen=4'b1111 and ram_address=13'h010; mem_ready pulses 2 cycles after the hit.
REQ-036 Write with strobe 4'b0100, then read the same address with READ_LATENCY=1 -> only byte 2 changes; mem_rdata is valid with mem_ready 2 cycles after the read hit.
REQ-037 Read with READ_LATENCY=2 -> one WAIT cycle; mem_ready 3 cycles after the hit; mem_rdata equals ram_rdata.
REQ-038 Access to 0x0000_2000 with BASE_ADDR=0 -> ram_sel, ram_wen and mem_ready stay 0 for 20 cycles.
REQ-039 Drop resetn during ACCESS of a write -> all outputs 0 immediately; no mem_ready after release; the next request completes normally.
REQ-040 Drop mem_valid one cycle after a read hit -> the transaction still completes with a single mem_ready pulse and no second ram_sel.

Source files
------------

// File: rtl/ram_bus_pkg.sv
// Shared definitions for the RAM bus controller: FSM state encoding and the
// supported range of RAM read latencies.
package ram_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } bus_state_e;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

    // A RAM that needs the full two edges gets an extra WAIT cycle before DONE.
    function automatic logic needs_wait(input int read_latency);
        return (read_latency >= READ_LATENCY_MAX) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/ram_bus_ctrl.sv
// picorv32 native-bus to synchronous RAM bridge: one strobed ACCESS cycle per
// request, optional WAIT for two-edge RAMs, and a single-cycle mem_ready pulse.
module ram_bus_ctrl
    import ram_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          ADDR_BITS    = 13,
    parameter int          READ_LATENCY = 1
) (
    input  logic                 clk_cpu,
    input  logic                 resetn,
    input  logic                 mem_valid,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wstrb,
    output logic                 mem_ready,
    output logic [31:0]          mem_rdata,
    output logic                 ram_sel,
    output logic [3:0]           ram_wen,
    output logic [ADDR_BITS-1:0] ram_address,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata
);

    localparam logic WAIT_EN = needs_wait(READ_LATENCY);

    bus_state_e state_r;
    logic       is_write_r;
    logic       hit_s;

    // Window decode: only the bits above the window size are compared.
    always_comb begin
        hit_s = 1'b0;
        if (mem_valid && (mem_addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS])) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Transaction FSM; every bus output is a register so the RAM sees clean strobes.
    always_ff @(posedge clk_cpu or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            is_write_r  <= 1'b0;
            mem_ready   <= 1'b0;
            mem_rdata   <= 32'h0000_0000;
            ram_sel     <= 1'b0;
            ram_wen     <= 4'b0000;
            ram_address <= '0;
            ram_wdata   <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mem_ready <= 1'b0;
                    if (hit_s) begin
                        is_write_r  <= (mem_wstrb != 4'b0000);
                        ram_sel     <= 1'b1;
                        ram_wen     <= mem_wstrb;
                        ram_address <= mem_addr[ADDR_BITS-1:0];
                        ram_wdata   <= mem_wdata;
                        state_r     <= ST_ACCESS;
                    end else begin
                        ram_sel <= 1'b0;
                        ram_wen <= 4'b0000;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    ram_sel <= 1'b0;
                    ram_wen <= 4'b0000;
                    if (is_write_r) begin
                        mem_ready <= 1'b1;
                        state_r   <= ST_DONE;
                    end else if (!WAIT_EN) begin
                        mem_rdata <= ram_rdata;
                        mem_ready <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    mem_rdata <= ram_rdata;
                    mem_ready <= 1'b1;
                    state_r   <= ST_DONE;
                end
                ST_DONE: begin
                    // No acceptance here: guarantees an IDLE cycle between requests.
                    mem_ready <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    mem_ready <= 1'b0;
                    ram_sel   <= 1'b0;
                    ram_wen   <= 4'b0000;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
